// File: rtl/serv_mem_if_w.sv
// Parametrised serial load/store unit: shifts W bits per cycle between the core
// datapath and a Wishbone data bus, with lane alignment, extension and traps.
module serv_mem_if_w #(
    parameter int W        = 1,
    parameter int WITH_CSR = 1,
    parameter int WITH_ERR = 1
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_start,
    input  logic          i_we,
    input  logic          i_signed,
    input  logic          i_word,
    input  logic          i_half,
    input  logic [1:0]    i_lsb,
    input  logic [W-1:0]  i_op_b,
    output logic [W-1:0]  o_rd,
    output logic          o_rd_valid,
    output logic          o_busy,
    output logic          o_done,
    output logic          o_misalign,
    output logic          o_err,
    output logic          o_wb_cyc,
    output logic          o_wb_we,
    output logic [3:0]    o_wb_sel,
    output logic [31:0]   o_wb_dat,
    input  logic [31:0]   i_wb_rdt,
    input  logic          i_wb_ack,
    input  logic          i_wb_err
);

    localparam int N  = 32 / W;
    localparam int CW = $clog2(N);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        SHIFT_IN  = 3'd1,
        BUS       = 3'd2,
        SHIFT_OUT = 3'd3,
        DONE      = 3'd4
    } state_t;

    state_t        state_q;
    logic [31:0]   dat_q;
    logic [CW-1:0] cnt_q;
    logic          we_q;
    logic          signed_q;
    logic          word_q;
    logic          half_q;
    logic [1:0]    lsb_q;
    logic          mis_q;
    logic          err_q;

    logic          misalign_s;
    logic          trap_s;
    logic          last_beat_s;
    logic          bus_err_s;
    logic          in_bus_s;
    logic [31:0]   rdt_shift_s;
    logic [31:0]   load_dat_d;

    function automatic logic [31:0] rotl_bytes(input logic [31:0] d, input logic [1:0] s);
        case (s)
            2'd0:    rotl_bytes = d;
            2'd1:    rotl_bytes = {d[23:0], d[31:24]};
            2'd2:    rotl_bytes = {d[15:0], d[31:16]};
            2'd3:    rotl_bytes = {d[7:0],  d[31:8]};
            default: rotl_bytes = d;
        endcase
    endfunction

    function automatic logic [3:0] lane_sel(input logic word, input logic half, input logic [1:0] s);
        if (word) begin
            lane_sel = 4'b1111;
        end else if (half) begin
            lane_sel = 4'b0011 << s;
        end else begin
            lane_sel = 4'b0001 << s;
        end
    endfunction

    // Request decode, beat bookkeeping and load-data alignment/extension.
    always_comb begin
        misalign_s  = (i_lsb[0] & (i_word | i_half)) | (i_lsb[1] & i_word);
        trap_s      = (WITH_CSR != 0) & misalign_s;
        bus_err_s   = (WITH_ERR != 0) & i_wb_err;
        last_beat_s = (cnt_q == CW'(N - 1));
        in_bus_s    = (state_q == BUS);
        rdt_shift_s = i_wb_rdt >> {lsb_q, 3'b000};
        load_dat_d  = rdt_shift_s;
        if (word_q) begin
            load_dat_d = rdt_shift_s;
        end else if (half_q) begin
            load_dat_d = {{16{signed_q & rdt_shift_s[15]}}, rdt_shift_s[15:0]};
        end else begin
            load_dat_d = {{24{signed_q & rdt_shift_s[7]}}, rdt_shift_s[7:0]};
        end
    end

    // Sequencer: owns the data shift register, beat counter and latched request.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q  <= IDLE;
            dat_q    <= 32'd0;
            cnt_q    <= '0;
            we_q     <= 1'b0;
            signed_q <= 1'b0;
            word_q   <= 1'b0;
            half_q   <= 1'b0;
            lsb_q    <= 2'd0;
            mis_q    <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (i_start) begin
                        we_q     <= i_we;
                        signed_q <= i_signed;
                        word_q   <= i_word;
                        half_q   <= i_half;
                        lsb_q    <= i_lsb;
                        cnt_q    <= '0;
                        mis_q    <= trap_s;
                        err_q    <= 1'b0;
                        if (trap_s) begin
                            state_q <= DONE;
                        end else if (i_we) begin
                            state_q <= SHIFT_IN;
                        end else begin
                            state_q <= BUS;
                        end
                    end
                end
                SHIFT_IN: begin
                    dat_q <= {i_op_b, dat_q[31:W]};
                    cnt_q <= cnt_q + CW'(1);
                    if (last_beat_s) begin
                        state_q <= BUS;
                    end
                end
                BUS: begin
                    // An error response takes precedence over a same-cycle ack.
                    if (bus_err_s) begin
                        err_q   <= 1'b1;
                        state_q <= DONE;
                    end else if (i_wb_ack) begin
                        if (we_q) begin
                            state_q <= DONE;
                        end else begin
                            dat_q   <= load_dat_d;
                            state_q <= SHIFT_OUT;
                        end
                    end
                end
                SHIFT_OUT: begin
                    dat_q <= {{W{1'b0}}, dat_q[31:W]};
                    cnt_q <= cnt_q + CW'(1);
                    if (last_beat_s) begin
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign o_busy     = (state_q != IDLE);
    assign o_done     = (state_q == DONE);
    assign o_misalign = o_done & mis_q;
    assign o_err      = o_done & err_q;
    assign o_rd_valid = (state_q == SHIFT_OUT);
    assign o_rd       = o_rd_valid ? dat_q[W-1:0] : {W{1'b0}};
    // Bus-side outputs are forced to zero outside BUS so the bus sees a clean idle.
    assign o_wb_cyc   = in_bus_s;
    assign o_wb_we    = in_bus_s & we_q;
    assign o_wb_sel   = in_bus_s ? lane_sel(word_q, half_q, lsb_q) : 4'b0000;
    assign o_wb_dat   = in_bus_s ? rotl_bytes(dat_q, lsb_q) : 32'd0;

endmodule

// File: tb/tb_serv_mem_if_w.sv
// Self-checking bench for serv_mem_if_w: four configurations (W = 1/4/8/2),
// directed cases plus randomized accesses against a word-level reference model.
module tb_serv_mem_if_w;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        start;
    logic [3:0]  start_a;
    logic        we, sgn, word, half;
    logic [1:0]  lsb;
    logic [7:0]  op_b;
    logic [31:0] rdt;
    logic        ack, err;
    logic [1:0]  sel;

    logic [3:0]       busy_a, done_a, mis_a, err_a, cyc_a, wwe_a, rdv_a;
    logic [3:0][3:0]  wsel_a;
    logic [3:0][31:0] wdat_a;
    logic [0:0]  rd0;
    logic [3:0]  rd1;
    logic [7:0]  rd2;
    logic [1:0]  rd3;

    logic        v_busy, v_done, v_mis, v_err, v_cyc, v_wwe, v_rdv;
    logic [3:0]  v_wsel;
    logic [31:0] v_wdat;
    logic [7:0]  v_rd;

    int checks   = 0;
    int failures = 0;

    assign start_a = start ? (4'b0001 << sel) : 4'b0000;

    serv_mem_if_w #(.W(1), .WITH_CSR(1), .WITH_ERR(1)) u_d0 (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(start_a[0]), .i_we(we), .i_signed(sgn),
        .i_word(word), .i_half(half), .i_lsb(lsb), .i_op_b(op_b[0:0]), .o_rd(rd0),
        .o_rd_valid(rdv_a[0]), .o_busy(busy_a[0]), .o_done(done_a[0]), .o_misalign(mis_a[0]),
        .o_err(err_a[0]), .o_wb_cyc(cyc_a[0]), .o_wb_we(wwe_a[0]), .o_wb_sel(wsel_a[0]),
        .o_wb_dat(wdat_a[0]), .i_wb_rdt(rdt), .i_wb_ack(ack), .i_wb_err(err));

    serv_mem_if_w #(.W(4), .WITH_CSR(1), .WITH_ERR(1)) u_d1 (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(start_a[1]), .i_we(we), .i_signed(sgn),
        .i_word(word), .i_half(half), .i_lsb(lsb), .i_op_b(op_b[3:0]), .o_rd(rd1),
        .o_rd_valid(rdv_a[1]), .o_busy(busy_a[1]), .o_done(done_a[1]), .o_misalign(mis_a[1]),
        .o_err(err_a[1]), .o_wb_cyc(cyc_a[1]), .o_wb_we(wwe_a[1]), .o_wb_sel(wsel_a[1]),
        .o_wb_dat(wdat_a[1]), .i_wb_rdt(rdt), .i_wb_ack(ack), .i_wb_err(err));

    serv_mem_if_w #(.W(8), .WITH_CSR(0), .WITH_ERR(0)) u_d2 (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(start_a[2]), .i_we(we), .i_signed(sgn),
        .i_word(word), .i_half(half), .i_lsb(lsb), .i_op_b(op_b[7:0]), .o_rd(rd2),
        .o_rd_valid(rdv_a[2]), .o_busy(busy_a[2]), .o_done(done_a[2]), .o_misalign(mis_a[2]),
        .o_err(err_a[2]), .o_wb_cyc(cyc_a[2]), .o_wb_we(wwe_a[2]), .o_wb_sel(wsel_a[2]),
        .o_wb_dat(wdat_a[2]), .i_wb_rdt(rdt), .i_wb_ack(ack), .i_wb_err(err));

    serv_mem_if_w #(.W(2), .WITH_CSR(0), .WITH_ERR(1)) u_d3 (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(start_a[3]), .i_we(we), .i_signed(sgn),
        .i_word(word), .i_half(half), .i_lsb(lsb), .i_op_b(op_b[1:0]), .o_rd(rd3),
        .o_rd_valid(rdv_a[3]), .o_busy(busy_a[3]), .o_done(done_a[3]), .o_misalign(mis_a[3]),
        .o_err(err_a[3]), .o_wb_cyc(cyc_a[3]), .o_wb_we(wwe_a[3]), .o_wb_sel(wsel_a[3]),
        .o_wb_dat(wdat_a[3]), .i_wb_rdt(rdt), .i_wb_ack(ack), .i_wb_err(err));

    // View of the currently selected instance.
    always_comb begin
        v_busy = busy_a[sel];
        v_done = done_a[sel];
        v_mis  = mis_a[sel];
        v_err  = err_a[sel];
        v_cyc  = cyc_a[sel];
        v_wwe  = wwe_a[sel];
        v_rdv  = rdv_a[sel];
        v_wsel = wsel_a[sel];
        v_wdat = wdat_a[sel];
        case (sel)
            2'd0:    v_rd = {7'd0, rd0};
            2'd1:    v_rd = {4'd0, rd1};
            2'd2:    v_rd = rd2;
            default: v_rd = {6'd0, rd3};
        endcase
    end

    function automatic int w_of(input int k);
        case (k)
            0:       return 1;
            1:       return 4;
            2:       return 8;
            default: return 2;
        endcase
    endfunction

    function automatic logic csr_of(input int k);
        return (k < 2);
    endfunction

    function automatic logic err_of(input int k);
        return (k != 2);
    endfunction

    function automatic logic [31:0] load_model(input logic [31:0] r, input logic sg,
                                               input logic wd, input logic hf, input logic [1:0] l);
        logic [31:0] v;
        v = r >> (8 * l);
        if (wd) return v;
        if (hf) return sg ? 32'($signed(v[15:0])) : 32'(v[15:0]);
        return sg ? 32'($signed(v[7:0])) : 32'(v[7:0]);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_busy"}, 32'(v_busy), 32'd0);
        chk({tag, "_done"}, 32'(v_done), 32'd0);
        chk({tag, "_flags"}, {30'd0, v_mis, v_err}, 32'd0);
        chk({tag, "_cyc"}, {30'd0, v_cyc, v_wwe}, 32'd0);
        chk({tag, "_sel"}, 32'(v_wsel), 32'd0);
        chk({tag, "_dat"}, v_wdat, 32'd0);
        chk({tag, "_rd"}, {23'd0, v_rdv, v_rd}, 32'd0);
    endtask

    // One access on instance k. em: 0 = ack, 1 = ack+err together, 2 = err alone.
    task automatic run_txn(input int k, input logic t_we, input logic t_sg, input logic t_wd,
                           input logic t_hf, input logic [1:0] t_lsb, input logic [31:0] t_dat,
                           input logic [31:0] t_rdt, input int t_wait, input int t_em, input logic noise);
        int wk, n, lat_exp, cyc_n, beats, lat, em;
        logic mis_exp, err_exp, got, rd_exp;
        logic [31:0] rd_word, dat_exp;
        logic [3:0]  sel_exp;
        logic [63:0] dd;
        wk = w_of(k);
        n  = 32 / wk;
        em = (!err_of(k) && t_em == 2) ? 1 : t_em;
        mis_exp = csr_of(k) && ((t_lsb[0] && (t_wd || t_hf)) || (t_lsb[1] && t_wd));
        err_exp = !mis_exp && (em != 0) && err_of(k);
        rd_exp  = !t_we && !mis_exp && !err_exp;
        dd = {t_dat, t_dat} << (8 * t_lsb);
        dat_exp = dd[63:32];
        sel_exp = t_wd ? 4'b1111 : (t_hf ? 4'(4'b0011 << t_lsb) : 4'(4'b0001 << t_lsb));
        if (mis_exp)      lat_exp = 1;
        else if (t_we)    lat_exp = n + t_wait + 2;
        else if (err_exp) lat_exp = t_wait + 2;
        else              lat_exp = t_wait + n + 2;

        sel = 2'(k); we = t_we; sgn = t_sg; word = t_wd; half = t_hf; lsb = t_lsb;
        rdt = t_rdt; ack = 1'b0; err = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        got = 1'b0; cyc_n = 0; beats = 0; rd_word = 32'd0; lat = 0;
        for (int c = 1; c <= 200 && !got; c++) begin
            start = noise ? 1'($urandom_range(1, 0)) : 1'b0;
            ack = 1'b0;
            err = 1'b0;
            if (t_we && !mis_exp && c <= n) op_b = 8'(t_dat >> (wk * (c - 1)));
            else op_b = 8'($urandom);
            if (v_done) begin
                got = 1'b1;
                lat = c;
                chk("misalign", 32'(v_mis), 32'(mis_exp));
                chk("err", 32'(v_err), 32'(err_exp));
            end else begin
                chk("busy", 32'(v_busy), 32'd1);
                chk("flags_off", {30'd0, v_mis, v_err}, 32'd0);
            end
            if (v_cyc) begin
                chk("wb_we", 32'(v_wwe), 32'(t_we));
                chk("wb_sel", 32'(v_wsel), 32'(sel_exp));
                if (t_we) chk("wb_dat", v_wdat, dat_exp);
                if (cyc_n == t_wait) begin
                    ack = (em != 2);
                    err = (em != 0);
                end
                cyc_n++;
            end else if (noise) begin
                ack = 1'($urandom_range(1, 0));
                err = 1'($urandom_range(1, 0));
            end
            if (v_rdv) begin
                rd_word = rd_word | (32'(v_rd) << (wk * beats));
                beats++;
            end else begin
                chk("rd_zero", 32'(v_rd), 32'd0);
            end
            @(posedge clk); #1;
        end
        start = 1'b0; ack = 1'b0; err = 1'b0;
        if (!got) begin
            chk("done_timeout", 32'd0, 32'd1);
        end else begin
            chk("latency", 32'(lat), 32'(lat_exp));
            chk("cyc_cycles", 32'(cyc_n), mis_exp ? 32'd0 : 32'(t_wait + 1));
            chk("rd_beats", 32'(beats), rd_exp ? 32'(n) : 32'd0);
            if (rd_exp) chk("load_data", rd_word, load_model(t_rdt, t_sg, t_wd, t_hf, t_lsb));
            chk("idle_after", {30'd0, v_busy, v_done}, 32'd0);
        end
    endtask

    // Word load on instance k, reset pulled mid-BUS (mode 0) or mid-SHIFT_OUT (mode 1).
    task automatic rst_test(input int k, input int mode);
        logic hit;
        int seen;
        sel = 2'(k); we = 1'b0; sgn = 1'b0; word = 1'b1; half = 1'b0; lsb = 2'd0;
        rdt = 32'hA5C3_1E0F; ack = 1'b0; err = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        hit = 1'b0;
        seen = 0;
        for (int c = 0; c < 100 && !hit; c++) begin
            ack = 1'b0;
            if ((mode == 0) ? (v_cyc && seen == 2) : (v_rdv && seen == 2)) begin
                hit = 1'b1;
            end else begin
                if (mode == 1 && v_cyc) ack = 1'b1;
                if ((mode == 0) ? v_cyc : v_rdv) seen++;
                @(posedge clk); #1;
            end
        end
        ack = 1'b0;
        chk("rst_reached", 32'(hit), 32'd1);
        #2 rst_n = 1'b0;
        #1 check_all_zero("rst_async");
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            chk("rst_no_done", 32'(v_done), 32'd0);
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
        check_all_zero("rst_release");
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; we = 1'b0; sgn = 1'b0; word = 1'b0; half = 1'b0;
        lsb = 2'd0; op_b = 8'd0; rdt = 32'd0; ack = 1'b0; err = 1'b0; sel = 2'd0;
        #3;
        for (int k = 0; k < 4; k++) begin
            sel = 2'(k);
            #1 check_all_zero("reset");
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        run_txn(0, 1'b1, 1'b0, 1'b1, 1'b0, 2'd0, 32'hDEADBEEF, 32'd0, 3, 0, 1'b0);
        run_txn(1, 1'b0, 1'b1, 1'b0, 1'b0, 2'd3, 32'd0, 32'h80123456, 0, 0, 1'b0);
        run_txn(1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd3, 32'd0, 32'h80123456, 0, 0, 1'b0);
        run_txn(2, 1'b1, 1'b0, 1'b0, 1'b1, 2'd2, 32'h00001234, 32'd0, 1, 0, 1'b0);
        run_txn(0, 1'b1, 1'b0, 1'b1, 1'b0, 2'd2, 32'h11223344, 32'd0, 0, 0, 1'b0);
        run_txn(1, 1'b0, 1'b0, 1'b0, 1'b1, 2'd1, 32'd0, 32'hCAFEF00D, 0, 0, 1'b0);
        run_txn(2, 1'b1, 1'b0, 1'b1, 1'b0, 2'd2, 32'h11223344, 32'd0, 0, 0, 1'b0);
        run_txn(2, 1'b0, 1'b1, 1'b0, 1'b1, 2'd1, 32'd0, 32'hCAFEF00D, 2, 0, 1'b0);
        run_txn(1, 1'b0, 1'b1, 1'b1, 1'b0, 2'd0, 32'd0, 32'h89ABCDEF, 2, 1, 1'b0);
        run_txn(2, 1'b0, 1'b1, 1'b1, 1'b0, 2'd0, 32'd0, 32'h89ABCDEF, 2, 1, 1'b0);
        run_txn(3, 1'b0, 1'b0, 1'b0, 1'b0, 2'd1, 32'd0, 32'h0000F700, 1, 2, 1'b0);

        rst_test(1, 1);
        run_txn(1, 1'b0, 1'b1, 1'b0, 1'b1, 2'd2, 32'd0, 32'h8001_7FFF, 1, 0, 1'b1);
        rst_test(0, 0);
        run_txn(0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd1, 32'h000000A5, 32'd0, 2, 0, 1'b1);

        for (int i = 0; i < 80; i++) begin
            run_txn(int'($urandom_range(3, 0)), 1'($urandom), 1'($urandom), 1'($urandom),
                    1'($urandom), 2'($urandom), $urandom, $urandom,
                    int'($urandom_range(3, 0)), ($urandom_range(3, 0) == 0) ? int'($urandom_range(2, 1)) : 0,
                    1'($urandom));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
